// File: rtl/lcrc_gen.sv
// Streaming reflected CRC-32 (LCRC) generator: one CRC and byte count per packet, DATA_W bits per beat.
// Define LCRC_CHECK_EN to add crc_exp / crc_err for receive-side LCRC checking.
module lcrc_gen #(
  parameter int DATA_W = 32,
  parameter int KEEP_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [KEEP_W-1:0] in_keep,
`ifdef LCRC_CHECK_EN
  input  logic [31:0]       crc_exp,
  output logic              crc_err,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       crc_out,
  output logic [15:0]       out_len,
  output logic [7:0]        drop_cnt
);

  localparam logic [31:0] POLY = 32'hEDB88320;

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t      state;
  logic [31:0] crc_acc;
  logic [15:0] len_acc;

  logic              accept;
  logic [KEEP_W-1:0] mask;
  logic [31:0]       seed;
  logic [15:0]       len_base;
  logic [31:0]       crc_next;
  logic [16:0]       len_sum;
  logic [15:0]       len_next;

  function automatic logic [31:0] crc_fold(input logic [31:0] c,
                                           input logic [DATA_W-1:0] d,
                                           input logic [KEEP_W-1:0] m);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < KEEP_W; i++) begin
      if (m[i]) begin
        r = r ^ {24'h0, d[8*i +: 8]};
        for (int b = 0; b < 8; b++)
          r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] byte_cnt(input logic [KEEP_W-1:0] m);
    logic [15:0] n;
    n = '0;
    for (int i = 0; i < KEEP_W; i++)
      if (m[i]) n = n + 16'd1;
    return n;
  endfunction

  assign in_ready = (state != HOLD) | out_ready;
  assign accept   = in_valid & in_ready;

  // Keep is only meaningful on the last beat; earlier beats always carry a full word.
  always_comb begin
    mask     = in_eop ? in_keep : {KEEP_W{1'b1}};
    seed     = in_sop ? 32'hFFFF_FFFF : crc_acc;
    len_base = in_sop ? 16'd0 : len_acc;
    crc_next = crc_fold(seed, in_data, mask);
    len_sum  = {1'b0, len_base} + {1'b0, byte_cnt(mask)};
    len_next = len_sum[16] ? 16'hFFFF : len_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      crc_acc   <= 32'hFFFF_FFFF;
      len_acc   <= '0;
      out_valid <= 1'b0;
      crc_out   <= '0;
      out_len   <= '0;
      drop_cnt  <= '0;
`ifdef LCRC_CHECK_EN
      crc_err   <= 1'b0;
`endif
    end else begin
      // A sop beat always (re)starts a packet, even if one is in flight.
      if (accept && (in_sop || state == BUSY)) begin
        if (in_eop) begin
          state     <= HOLD;
          out_valid <= 1'b1;
          crc_out   <= ~crc_next;
          out_len   <= len_next;
`ifdef LCRC_CHECK_EN
          crc_err   <= (~crc_next != crc_exp);
`endif
        end else begin
          state     <= BUSY;
          out_valid <= 1'b0;
          crc_acc   <= crc_next;
          len_acc   <= len_next;
        end
      end else begin
        // Here an accepted beat arrived in IDLE (or HOLD being released) without sop.
        if (accept && drop_cnt != 8'hFF)
          drop_cnt <= drop_cnt + 8'd1;
        if (state == HOLD && out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_lcrc_gen.sv
// Directed bench for lcrc_gen with a result scoreboard drained by a monitor.
module tb_lcrc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_sop;
  logic        in_eop;
  logic [3:0]  in_keep;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] crc_out;
  logic [15:0] out_len;
  logic [7:0]  drop_cnt;
  logic [31:0] crc_exp;
`ifdef LCRC_CHECK_EN
  logic        crc_err;
`endif

  typedef struct packed {
    logic [31:0] crc;
    logic [15:0] len;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  lcrc_gen #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .in_keep   (in_keep),
`ifdef LCRC_CHECK_EN
    .crc_exp   (crc_exp),
    .crc_err   (crc_err),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .crc_out   (crc_out),
    .out_len   (out_len),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every result handshake pops one expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_crc", crc_out, e.crc);
        check("sb_len", {16'd0, out_len}, {16'd0, e.len});
`ifdef LCRC_CHECK_EN
        check("sb_err", {31'd0, crc_err}, {31'd0, e.err});
`endif
      end
    end
  end

  // Drive one beat just after a rising edge and hold it until accepted.
  task automatic send_beat(input logic [31:0] d, input logic s, input logic e,
                           input logic [3:0] k, input logic [31:0] ce);
    int n;
    in_data  = d;
    in_sop   = s;
    in_eop   = e;
    in_keep  = k;
    crc_exp  = ce;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  // "123456789" in three beats; expected CRC is the CRC-32 check value.
  task automatic send_9(input logic [31:0] ce, input logic err);
    sb.push_back('{crc: 32'hCBF43926, len: 16'd9, err: err});
    send_beat(32'h34333231, 1'b1, 1'b0, 4'hF, 32'h0);
    send_beat(32'h38373635, 1'b0, 1'b0, 4'hF, 32'h0);
    send_beat(32'h00000039, 1'b0, 1'b1, 4'b0001, ce);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0;
    in_valid = 1'b0; in_data = '0; in_sop = 1'b0; in_eop = 1'b0; in_keep = '0;
    crc_exp = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_crc_out", crc_out, 32'd0);
    check("rst_out_len", {16'd0, out_len}, 32'd0);
    check("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Multi-beat packet with a partial last beat; result on the eop edge.
    send_9(32'hCBF43926, 1'b0);
    @(negedge clk);
    check("lat_out_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    check("released_out_valid", {31'd0, out_valid}, 32'd0);

    // Single-beat packets back-to-back, one per cycle.
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{crc: 32'h9BE3E0A3, len: 16'd4, err: 1'b1});
      in_data = 32'h34333231; in_sop = 1'b1; in_eop = 1'b1; in_keep = 4'hF;
      crc_exp = 32'h0; in_valid = 1'b1;
      @(negedge clk);
      check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
      check("b2b_out_valid", {31'd0, out_valid}, (i > 0) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    @(negedge clk);
    check("b2b_last_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;

    // Backpressure: result held, next beat waits and is not lost.
    out_ready = 1'b0;
    sb.push_back('{crc: 32'h9BE3E0A3, len: 16'd4, err: 1'b1});
    send_beat(32'h34333231, 1'b1, 1'b1, 4'hF, 32'h0);
    sb.push_back('{crc: 32'hCBF43926, len: 16'd9, err: 1'b0});
    in_data = 32'h00000000; in_sop = 1'b1; in_eop = 1'b1; in_keep = 4'h0;
    crc_exp = 32'h0; in_valid = 1'b1;
    sb[1] = '{crc: 32'h0, len: 16'd0, err: 1'b0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
      check("hold_crc_out", crc_out, 32'h9BE3E0A3);
      check("hold_out_len", {16'd0, out_len}, 32'd4);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("hold_release_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    @(negedge clk);
    check("zero_len_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    check("back_to_idle", {31'd0, out_valid}, 32'd0);

    // Drops while idle, then a mid-packet restart.
    @(posedge clk); #1;
    send_beat(32'hDEADBEEF, 1'b0, 1'b0, 4'hF, 32'h0);
    send_beat(32'h12345678, 1'b0, 1'b1, 4'hF, 32'h0);
    @(negedge clk);
    check("drop_cnt", {24'd0, drop_cnt}, 32'd2);
    check("drop_no_output", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    send_beat(32'h34333231, 1'b1, 1'b0, 4'hF, 32'h0);
    send_beat(32'h38373635, 1'b0, 1'b0, 4'hF, 32'h0);
    send_9(32'hCBF43926, 1'b0);
    repeat (2) @(negedge clk);
    check("drop_cnt_after", {24'd0, drop_cnt}, 32'd2);

    // Reset in the middle of a packet.
    @(posedge clk); #1;
    send_beat(32'h34333231, 1'b1, 1'b0, 4'hF, 32'h0);
    in_data = 32'h38373635; in_valid = 1'b1; in_keep = 4'hF;
    #2 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    check("mid_rst_crc_out", crc_out, 32'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    send_9(32'hCBF43926, 1'b0);

`ifdef LCRC_CHECK_EN
    send_9(32'h00000000, 1'b1);
`endif

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lcrc_gen.md
# lcrc_gen

Parametrised streaming LCRC-32 generator for the data link layer. It sits between the TLP sequencer and the replay buffer. TLP bytes arrive on a valid/ready stream of DATA_W bits per beat, framed by start- and end-of-packet flags. The block returns one 32-bit LCRC plus a byte count per packet on a second valid/ready stream. It replaces the fixed 96-bit combinational CRC stage, so TLPs of any length and any beat width are supported.

## Interface
- DATA_W, 32, beat width in bits; multiple of 8, range 8..128; KEEP_W = DATA_W/8 is derived.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept the beat.
- in_data  in  DATA_W  TLP bytes; byte 0 is in_data[7:0] and is the first byte on the wire.
- in_sop  in  1  first beat of a TLP.
- in_eop  in  1  last beat of a TLP.
- in_keep  in  KEEP_W  byte-valid mask, contiguous from bit 0; honoured only on eop beats (all ones otherwise).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- crc_out  out  32  final LCRC.
- out_len  out  16  packet byte count, saturating at 0xFFFF.
- drop_cnt  out  8  count of beats dropped while IDLE, saturating at 0xFF.

## Operation
- CRC definition: reflected CRC-32, polynomial 0xEDB88320, init 0xFFFFFFFF, bits LSB-first within each byte, final XOR 0xFFFFFFFF. An unrolled per-byte loop is combined with keep masking.
- A beat is accepted when in_valid & in_ready.
- FSM states:
  - IDLE:
    - Accepted beat with in_sop: seed crc=0xFFFFFFFF, fold in the beat, set len to the beat's byte count, go to BUSY.
    - Same beat also carrying in_eop: go to HOLD instead.
    - Accepted beat without in_sop: drop it and increment drop_cnt.
  - BUSY:
    - Accepted beat without in_eop: fold in all KEEP_W bytes.
    - Accepted beat with in_eop: fold in only the bytes set in in_keep, then go to HOLD.
    - Accepted beat with in_sop: abort the current packet, reseed, and restart from this beat (the same rules as IDLE+sop). No output is produced for the aborted packet.
  - HOLD:
    - out_valid=1; crc_out and out_len stay stable.
    - On out_ready, go to IDLE, or process the simultaneously accepted beat exactly as IDLE would.
- in_ready = (state != HOLD) | out_ready. This allows one packet per cycle when single-beat packets are back-to-back.
- in_keep = 0 on an eop beat adds no bytes. A zero-length packet gives crc_out = 0x00000000 and out_len = 0.
- Reset values: state IDLE, out_valid=0, crc_out=0, out_len=0, drop_cnt=0. in_ready=1 from the first cycle after reset release.
- Reset asserted mid-packet discards the packet. No output is produced for it.

## Timing
- Result latency: out_valid rises on the clock edge that accepts the eop beat (1 cycle). It stays high until out_ready is sampled high.
- Throughput: one beat per cycle in IDLE and BUSY.
- Output is registered. No combinational path from in_* to out_*.
- in_ready depends combinationally on out_ready and on the state register only.

## Configuration
- LCRC_CHECK_EN defined:
  - Adds input crc_exp[31:0], sampled on the eop beat.
  - Adds output crc_err (reset 0). crc_err is valid with out_valid and equals (computed CRC != crc_exp).
  - This lets the receive path reuse the block for the LCRC check.
- LCRC_CHECK_EN undefined:
  - Neither port exists and no compare logic is built.
  - All other behaviour is identical.

## Test plan
- DATA_W=32; beats 0x34333231 (sop), 0x38373635, then 0x00000039 (eop, keep=4'b0001) -> crc_out=0xCBF43926, out_len=9, out_valid one cycle after the eop beat.
- Single beat 0x34333231 with sop=eop=1, keep=4'hF -> crc_out=0x9BE3E0A3, out_len=4. Repeat back-to-back with out_ready=1 -> one result per cycle, in_ready held at 1.
- Hold out_ready=0 for 5 cycles after a result -> in_ready=0, crc_out stable, no beats lost. Then out_ready=1 -> state returns to IDLE.
- Send 2 beats without sop while IDLE, then a new sop beat mid-packet in BUSY:
  - drop_cnt=2.
  - Only the restarted packet reports, and its CRC matches a fresh computation.
- Assert rst low during the second beat of a packet -> out_valid=0, drop_cnt=0, crc_out=0. The next "123456789" packet gives 0xCBF43926.
- With LCRC_CHECK_EN defined:
  - "123456789" with crc_exp=0xCBF43926 -> crc_err=0.
  - The same packet with crc_exp=0 -> crc_err=1.
